// File: rtl/multireg_burst_arbiter.sv
// Round-robin arbiter that runs one requester's burst command at a time as an AXI4 INCR burst.
// Optional: define MULTIREG_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module multireg_burst_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*8-1:0]            req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
  input  logic [NUM_REQ-1:0]              wr_valid,
  output logic [NUM_REQ-1:0]              wr_ready,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [NUM_REQ-1:0]              rd_valid,
  output logic                            rd_last,
  output logic [NUM_REQ-1:0]              done,
  output logic [1:0]                      done_resp,
  output logic [ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_AW, S_AR, S_W, S_B, S_R, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [IW-1:0]           r_g;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_len;
  logic [7:0]              r_cnt;
  logic [1:0]              r_resp;
  logic                    r_mis;
`ifndef MULTIREG_ARB_FIXED_PRIO_EN
  logic [IW-1:0]           r_ptr;
  logic [IW:0]             w_idx;
`endif

  logic [IW-1:0]           w_win;
  logic                    w_found;
  logic [7:0]              w_len_sel;
  logic                    w_illegal;
  logic [NUM_REQ-1:0]      w_g_oh;
  logic [DATA_WIDTH-1:0]   w_wdata_g;
  logic                    w_rmis;
  logic [1:0]              w_rresp_max;

  // Winner selection: first valid requester at/after the pointer, or lowest index in fixed mode
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
`ifdef MULTIREG_ARB_FIXED_PRIO_EN
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_win   = IW'(k);
        w_found = 1'b1;
      end
    end
`else
    w_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (IW+1)'(r_ptr) + (IW+1)'(k);
      if (w_idx >= (IW+1)'(NUM_REQ)) w_idx = w_idx - (IW+1)'(NUM_REQ);
      if (!w_found && req_valid[w_idx[IW-1:0]]) begin
        w_win   = w_idx[IW-1:0];
        w_found = 1'b1;
      end
    end
`endif
  end

  assign w_len_sel   = req_len[int'(w_win)*8 +: 8];
  assign w_illegal   = {1'b0, w_len_sel} >= 9'(MAX_BEATS);
  assign w_g_oh      = NUM_REQ'(1) << r_g;
  assign w_wdata_g   = wr_data[int'(r_g)*DATA_WIDTH +: DATA_WIDTH];
  // A beat is out of place if RLAST disagrees with the requested length
  assign w_rmis      = M_AXI_RLAST ? (r_cnt != r_len) : (r_cnt >= r_len);
  assign w_rresp_max = (M_AXI_RRESP > r_resp) ? M_AXI_RRESP : r_resp;

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Command capture, beat counting and response accumulation
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_g    <= '0;
      r_addr <= '0;
      r_len  <= '0;
      r_cnt  <= '0;
      r_resp <= '0;
      r_mis  <= 1'b0;
`ifndef MULTIREG_ARB_FIXED_PRIO_EN
      r_ptr  <= '0;
`endif
    end else begin
      case (r_state)
        S_GRANT: begin
          if (w_found) begin
            r_g    <= w_win;
            r_addr <= req_addr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
            r_len  <= w_len_sel;
            r_cnt  <= '0;
            r_mis  <= 1'b0;
            r_resp <= w_illegal ? 2'b10 : 2'b00;
          end
        end
        S_W: begin
          if (wr_valid[r_g] && M_AXI_WREADY && (r_cnt != r_len)) r_cnt <= r_cnt + 8'd1;
        end
        S_B: begin
          if (M_AXI_BVALID) r_resp <= M_AXI_BRESP;
        end
        S_R: begin
          if (M_AXI_RVALID) begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
            if (M_AXI_RLAST) begin
              r_resp <= (r_mis || w_rmis) ? 2'b10 : w_rresp_max;
            end else begin
              r_resp <= w_rresp_max;
              r_mis  <= r_mis | w_rmis;
            end
          end
        end
`ifndef MULTIREG_ARB_FIXED_PRIO_EN
        S_DONE: begin
          r_ptr <= (r_g == IW'(NUM_REQ - 1)) ? '0 : r_g + IW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  assign done_resp = r_resp;

  // Next state and per-phase handshake outputs
  always_comb begin
    w_next        = r_state;
    req_ready     = '0;
    wr_ready      = '0;
    rd_data       = '0;
    rd_valid      = '0;
    rd_last       = 1'b0;
    done          = '0;
    M_AXI_AWADDR  = '0;
    M_AXI_AWLEN   = '0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARADDR  = '0;
    M_AXI_ARLEN   = '0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_next = S_GRANT;
      end
      S_GRANT: begin
        if (w_found) begin
          req_ready = NUM_REQ'(1) << w_win;
          if (w_illegal)           w_next = S_DONE;
          else if (req_write[w_win]) w_next = S_AW;
          else                     w_next = S_AR;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_AW: begin
        M_AXI_AWADDR  = r_addr;
        M_AXI_AWLEN   = r_len;
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) w_next = S_W;
      end
      S_AR: begin
        M_AXI_ARADDR  = r_addr;
        M_AXI_ARLEN   = r_len;
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) w_next = S_R;
      end
      S_W: begin
        M_AXI_WDATA  = w_wdata_g;
        M_AXI_WSTRB  = '1;
        M_AXI_WVALID = wr_valid[r_g];
        M_AXI_WLAST  = (r_cnt == r_len);
        wr_ready     = M_AXI_WREADY ? w_g_oh : '0;
        if (wr_valid[r_g] && M_AXI_WREADY && (r_cnt == r_len)) w_next = S_B;
      end
      S_B: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) w_next = S_DONE;
      end
      S_R: begin
        M_AXI_RREADY = 1'b1;
        rd_data      = M_AXI_RDATA;
        rd_valid     = M_AXI_RVALID ? w_g_oh : '0;
        rd_last      = M_AXI_RVALID & M_AXI_RLAST;
        if (M_AXI_RVALID && M_AXI_RLAST) w_next = S_DONE;
      end
      S_DONE: begin
        done   = w_g_oh;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multireg_burst_arbiter.sv
// Directed bench for multireg_burst_arbiter: command table, round-robin sequence, mid-burst reset.
module tb_multireg_burst_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [1:0]  req_valid, req_ready, req_write, wr_valid, wr_ready, rd_valid, done;
  logic [63:0] req_addr, wr_data;
  logic [15:0] req_len;
  logic [31:0] rd_data;
  logic        rd_last;
  logic [1:0]  done_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  multireg_burst_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BEATS(8)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .done(done), .done_resp(done_resp),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARVALID(M_AXI_ARVALID),
    .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // Zero-wait AXI slave with a small word memory and injectable responses
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [7:0]  cfg_rlast_at;
  logic [31:0] mem [64];
  logic [5:0]  s_awidx, s_aridx;
  logic [7:0]  s_wbeat, s_rbeat, s_rlast_at;
  logic        s_bvalid, s_rvalid;
  int          aw_hs = 0;
  int          ar_hs = 0;

  assign M_AXI_AWREADY = 1'b1;
  assign M_AXI_WREADY  = 1'b1;
  assign M_AXI_ARREADY = 1'b1;
  assign M_AXI_BVALID  = s_bvalid;
  assign M_AXI_BRESP   = s_bvalid ? cfg_bresp : 2'b00;
  assign M_AXI_RVALID  = s_rvalid;
  assign M_AXI_RDATA   = mem[s_aridx + s_rbeat[5:0]];
  assign M_AXI_RLAST   = s_rvalid && (s_rbeat == s_rlast_at);
  assign M_AXI_RRESP   = (s_rvalid && s_rbeat == 8'd0) ? cfg_rresp : 2'b00;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_wbeat  <= '0;
      s_rbeat  <= '0;
    end else begin
      if (M_AXI_AWVALID) begin
        s_awidx <= M_AXI_AWADDR[7:2];
        s_wbeat <= '0;
        aw_hs   <= aw_hs + 1;
      end
      if (M_AXI_WVALID) begin
        mem[s_awidx + s_wbeat[5:0]] <= M_AXI_WDATA;
        s_wbeat <= s_wbeat + 8'd1;
        if (M_AXI_WLAST) s_bvalid <= 1'b1;
      end
      if (s_bvalid && M_AXI_BREADY) s_bvalid <= 1'b0;
      if (M_AXI_ARVALID) begin
        s_aridx    <= M_AXI_ARADDR[7:2];
        s_rbeat    <= '0;
        s_rvalid   <= 1'b1;
        s_rlast_at <= (cfg_rlast_at == 8'hFF) ? M_AXI_ARLEN : cfg_rlast_at;
        ar_hs      <= ar_hs + 1;
      end else if (s_rvalid && M_AXI_RREADY) begin
        if (M_AXI_RLAST) s_rvalid <= 1'b0;
        else             s_rbeat  <= s_rbeat + 8'd1;
      end
    end
  end

  typedef struct {
    int          req;
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [31:0] base;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [7:0]  rlast_at;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] onehot(input int i);
    logic [1:0] one;
    one = 2'b01;
    return one << i;
  endfunction

  function automatic logic any_out();
    return |{req_ready, wr_ready, rd_valid, rd_last, done, done_resp, rd_data,
             M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB,
             M_AXI_WLAST, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARLEN,
             M_AXI_ARVALID, M_AXI_RREADY};
  endfunction

  function automatic vec_t mk(input int req, input bit wr, input logic [31:0] addr,
                              input logic [7:0] len, input logic [31:0] base,
                              input logic [1:0] bresp, input logic [1:0] rresp,
                              input logic [7:0] rlast_at, input logic [1:0] exp_resp);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.len = len; v.base = base;
    v.bresp = bresp; v.rresp = rresp; v.rlast_at = rlast_at; v.exp_resp = exp_resp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int         wb, rb, cyc, aw0, ar0;
    bit         got, granted, drop, legal;
    logic [7:0] eff;
    legal = (v.len < 8'd8);
    eff   = (v.rlast_at == 8'hFF) ? v.len : v.rlast_at;
    cfg_bresp = v.bresp; cfg_rresp = v.rresp; cfg_rlast_at = v.rlast_at;
    aw0 = aw_hs; ar0 = ar_hs;
    req_write[v.req]            = v.wr;
    req_addr[v.req*32 +: 32]    = v.addr;
    req_len[v.req*8 +: 8]       = v.len;
    wr_data[v.req*32 +: 32]     = v.base;
    wr_valid[v.req]             = v.wr;
    req_valid[v.req]            = 1'b1;
    wb = 0; rb = 0; cyc = 0; got = 1'b0; granted = 1'b0;
    while (!got && cyc < 200) begin
      @(negedge ACLK);
      cyc++;
      drop = 1'b0;
      if (!granted && req_ready != 2'b00) begin
        check("grant", 64'(req_ready), 64'(onehot(v.req)));
        granted = 1'b1;
        drop    = 1'b1;
      end
      if (M_AXI_AWVALID) begin
        check("awaddr", 64'(M_AXI_AWADDR), 64'(v.addr));
        check("awlen", 64'(M_AXI_AWLEN), 64'(v.len));
      end
      if (M_AXI_ARVALID) begin
        check("araddr", 64'(M_AXI_ARADDR), 64'(v.addr));
        check("arlen", 64'(M_AXI_ARLEN), 64'(v.len));
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        check("wr_ready", 64'(wr_ready), 64'(onehot(v.req)));
        check("wdata", 64'(M_AXI_WDATA), 64'(v.base + 32'(wb)));
        check("wlast", 64'(M_AXI_WLAST), 64'(wb == int'(v.len)));
        wb++;
      end
      if (rd_valid != 2'b00) begin
        check("rd_valid", 64'(rd_valid), 64'(onehot(v.req)));
        check("rd_data", 64'(rd_data), 64'(v.base + 32'(rb)));
        check("rd_last", 64'(rd_last), 64'(rb == int'(eff)));
        rb++;
      end
      if (done != 2'b00) begin
        check("done", 64'(done), 64'(onehot(v.req)));
        check("done_resp", 64'(done_resp), 64'(v.exp_resp));
        got = 1'b1;
      end
      @(posedge ACLK);
      #1;
      if (drop) req_valid[v.req] = 1'b0;
      wr_data[v.req*32 +: 32] = v.base + 32'(wb);
    end
    check("done_timeout", 64'(got), 64'd1);
    wr_valid[v.req]  = 1'b0;
    req_valid[v.req] = 1'b0;
    check("w_beats", 64'(wb), (legal && v.wr) ? 64'(v.len) + 64'd1 : 64'd0);
    check("r_beats", 64'(rb), (legal && !v.wr) ? 64'(eff) + 64'd1 : 64'd0);
    check("aw_count", 64'(aw_hs - aw0), (legal && v.wr) ? 64'd1 : 64'd0);
    check("ar_count", 64'(ar_hs - ar0), (legal && !v.wr) ? 64'd1 : 64'd0);
    @(negedge ACLK);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  exp_ord [4];
    int  wb, cyc, g, d, last_done;
    bit  hit, drop;

    vecs[0] = mk(0, 1'b1, 32'h00, 8'd7, 32'h1,   2'b00, 2'b00, 8'hFF, 2'b00);
    vecs[1] = mk(1, 1'b0, 32'h00, 8'd7, 32'h1,   2'b00, 2'b00, 8'hFF, 2'b00);
    vecs[2] = mk(0, 1'b1, 32'h00, 8'd8, 32'hDEAD, 2'b00, 2'b00, 8'hFF, 2'b10);
    vecs[3] = mk(1, 1'b1, 32'h40, 8'd3, 32'h100, 2'b10, 2'b00, 8'hFF, 2'b10);
    vecs[4] = mk(0, 1'b0, 32'h40, 8'd3, 32'h100, 2'b00, 2'b00, 8'hFF, 2'b00);
    vecs[5] = mk(1, 1'b1, 32'h80, 8'd0, 32'hAA,  2'b00, 2'b00, 8'hFF, 2'b00);
    vecs[6] = mk(0, 1'b0, 32'h80, 8'd0, 32'hAA,  2'b00, 2'b00, 8'hFF, 2'b00);
    vecs[7] = mk(1, 1'b0, 32'h00, 8'd3, 32'h1,   2'b00, 2'b01, 8'hFF, 2'b01);
    vecs[8] = mk(0, 1'b0, 32'h00, 8'd3, 32'h1,   2'b00, 2'b00, 8'd1,  2'b10);
    vecs[9] = mk(1, 1'b0, 32'h00, 8'd1, 32'h1,   2'b00, 2'b00, 8'd3,  2'b10);

`ifdef MULTIREG_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 0, 1};
`endif

    ARESETN = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    wr_data = '0; wr_valid = '0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rlast_at = 8'hFF;
    repeat (3) @(negedge ACLK);
    check("reset_outs", 64'(any_out()), 64'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("idle_outs", 64'(any_out()), 64'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset during the 4th write beat of an 8-beat burst
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rlast_at = 8'hFF;
    req_write[0] = 1'b1; req_addr[31:0] = 32'hC0; req_len[7:0] = 8'd7;
    wr_data[31:0] = 32'h500; wr_valid[0] = 1'b1; req_valid[0] = 1'b1;
    wb = 0; cyc = 0; hit = 1'b0;
    while (!hit && cyc < 100) begin
      @(negedge ACLK);
      cyc++;
      drop = req_ready[0];
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (wb == 3) hit = 1'b1;
        else         wb++;
      end
      if (!hit) begin
        @(posedge ACLK);
        #1;
        if (drop) req_valid[0] = 1'b0;
        wr_data[31:0] = 32'h500 + 32'(wb);
      end
    end
    check("rst_reach_beat4", 64'(hit), 64'd1);
    ARESETN = 1'b0;
    #1;
    check("rst_async_outs", 64'(any_out()), 64'd0);
    check("rst_async_wvalid", 64'(M_AXI_WVALID), 64'd0);
    check("rst_async_wready", 64'(wr_ready), 64'd0);
    req_valid = '0; wr_valid = '0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check("rst_no_done", 64'(done), 64'd0);
    end

    // Both requesters held valid for four back-to-back reads
    req_write = 2'b00;
    req_addr  = {32'h80, 32'h80};
    req_len   = '0;
    req_valid = 2'b11;
    g = 0; d = 0; cyc = 0; last_done = -100;
    while (d < 4 && cyc < 300) begin
      @(negedge ACLK);
      cyc++;
      drop = 1'b0;
      if (req_ready != 2'b00 && g < 4) begin
        check("rr_grant", 64'(req_ready), 64'(onehot(exp_ord[g])));
        if (g > 0) check("rr_gap", 64'((cyc - last_done) >= 2), 64'd1);
        g++;
        if (g == 4) drop = 1'b1;
      end
      if (done != 2'b00 && d < 4) begin
        check("rr_done", 64'(done), 64'(onehot(exp_ord[d])));
        check("rr_resp", 64'(done_resp), 64'd0);
        d++;
        last_done = cyc;
      end
      @(posedge ACLK);
      #1;
      if (drop) req_valid = 2'b00;
    end
    check("rr_done_count", 64'(d), 64'd4);
    @(negedge ACLK);

    run_vec(vecs[4]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
